imm_ext_arbiter: RTL and testbench

//  Shares one 16->32 immediate extender between the two decode lanes of the dual-issue front end.

---
 rtl/imm_ext_arbiter.sv | 112 +++++++++++
 tb/tb_imm_ext_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_arbiter.sv
// Arbitrates two decode lanes onto one shared 16->32 immediate extender,
// holding the extended value and its source lane in a 1-entry output register.
module imm_ext_arbiter #(
  parameter int FIXED_PRI = 0,
  parameter int MAX_WAIT  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_imm,
  input  logic        req0_extop,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_imm,
  input  logic        req1_extop,
  output logic        req1_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_lane,
  input  logic        out_ready
);

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_lane_q, out_lane_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;

  logic        slot_free;
  logic        lane1_wins;
  logic        grant0, grant1;
  logic [15:0] sel_imm;
  logic        sel_extop;

  // Tie-break: round-robin points away from the last winner; fixed priority
  // yields to lane 1 only once its loss counter reaches the limit.
  always_comb begin
    slot_free = !out_valid_q || out_ready;
    if (FIXED_PRI == 0) begin
      lane1_wins = !rr_ptr_q;
    end else begin
      lane1_wins = (wait_cnt_q == WAIT_LIM);
    end
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && slot_free) begin
      if (req0_valid && req1_valid) begin
        grant1 = lane1_wins;
        grant0 = !lane1_wins;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  always_comb begin
    sel_imm   = grant1 ? req1_imm : req0_imm;
    sel_extop = grant1 ? req1_extop : req0_extop;

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_lane_d  = out_lane_q;
    rr_ptr_d    = rr_ptr_q;
    wait_cnt_d  = wait_cnt_q;

    if (grant0 || grant1) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_extop ? {{16{sel_imm[15]}}, sel_imm} : {16'h0000, sel_imm};
      out_lane_d  = grant1;
      rr_ptr_d    = grant1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Counts lane-1 losses only; grant0 already implies a free slot.
    if (FIXED_PRI != 0) begin
      if (grant1) begin
        wait_cnt_d = 4'd0;
      end else if (grant0 && req1_valid && (wait_cnt_q != WAIT_LIM)) begin
        wait_cnt_d = wait_cnt_q + 4'd1;
      end
    end else begin
      wait_cnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0000_0000;
      out_lane_q  <= 1'b0;
      rr_ptr_q    <= 1'b1;
      wait_cnt_q  <= 4'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lane_q  <= out_lane_d;
      rr_ptr_q    <= rr_ptr_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_lane   = out_lane_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Drives a round-robin instance (index 0) and a fixed-priority instance
// (index 1, MAX_WAIT=3) against a transaction-level reference model.
module tb_imm_ext_arbiter;

  localparam int MAXW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v0[2], v1[2], e0[2], e1[2], ordy[2];
  logic [15:0] i0[2], i1[2];
  logic        r0[2], r1[2], ov[2], ol[2];
  logic [31:0] od[2];

  int tests = 0;
  int fails = 0;
  int g_prev[2];

  // Reference model: pending result plus arbitration history per instance
  logic        m_ov[2];
  logic [31:0] m_od[2];
  logic        m_ol[2];
  int          m_last[2];
  int          m_loss[2];

  imm_ext_arbiter #(.FIXED_PRI(0), .MAX_WAIT(MAXW)) u_rr (
    .clk(clk), .rst(rst),
    .req0_valid(v0[0]), .req0_imm(i0[0]), .req0_extop(e0[0]), .req0_ready(r0[0]),
    .req1_valid(v1[0]), .req1_imm(i1[0]), .req1_extop(e1[0]), .req1_ready(r1[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_lane(ol[0]), .out_ready(ordy[0])
  );

  imm_ext_arbiter #(.FIXED_PRI(1), .MAX_WAIT(MAXW)) u_fp (
    .clk(clk), .rst(rst),
    .req0_valid(v0[1]), .req0_imm(i0[1]), .req0_extop(e0[1]), .req0_ready(r0[1]),
    .req1_valid(v1[1]), .req1_imm(i1[1]), .req1_extop(e1[1]), .req1_ready(r1[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_lane(ol[1]), .out_ready(ordy[1])
  );

  function automatic logic [31:0] ext16(input logic [15:0] imm, input logic sx);
    int unsigned val;
    val = imm;
    if (sx && val >= 32768) val = val + 32'hFFFF_0000;
    return val;
  endfunction

  function automatic int pick(input int d);
    if (rst) return -1;
    if (m_ov[d] && !ordy[d]) return -1;
    if (v0[d] && v1[d]) begin
      if (d == 0) return (m_last[d] == 0) ? 1 : 0;
      return (m_loss[d] == MAXW) ? 1 : 0;
    end
    if (v0[d]) return 0;
    if (v1[d]) return 1;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    int g[2];
    #1;
    for (int d = 0; d < 2; d++) begin
      g[d] = pick(d);
      chk($sformatf("ready0[%0d]", d), 32'(r0[d]), 32'(g[d] == 0));
      chk($sformatf("ready1[%0d]", d), 32'(r1[d]), 32'(g[d] == 1));
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_ov[d] = 1'b0; m_od[d] = 32'h0; m_ol[d] = 1'b0; m_last[d] = 1; m_loss[d] = 0;
        g[d] = -1;
      end else if (g[d] >= 0) begin
        m_ov[d] = 1'b1;
        m_ol[d] = (g[d] == 1);
        m_od[d] = (g[d] == 1) ? ext16(i1[d], e1[d]) : ext16(i0[d], e0[d]);
        m_last[d] = g[d];
        if (g[d] == 1) m_loss[d] = 0;
        else if (v1[d] && m_loss[d] < MAXW) m_loss[d]++;
      end else if (m_ov[d] && ordy[d]) begin
        m_ov[d] = 1'b0;
      end
      g_prev[d] = g[d];
      chk($sformatf("out_valid[%0d]", d), 32'(ov[d]), 32'(m_ov[d]));
      chk($sformatf("out_data[%0d]", d), od[d], m_od[d]);
      chk($sformatf("out_lane[%0d]", d), 32'(ol[d]), 32'(m_ol[d]));
      $display("[TB] t=%0t dut%0d grant=%0d out_valid=%0d out_data=%h out_lane=%0d",
               $time, d, g[d], ov[d], od[d], ol[d]);
    end
  endtask

  task automatic new_req(input int d, input int lane, input logic valid);
    logic [15:0] imm;
    logic e;
    imm = 16'($urandom);
    e = 1'($urandom);
    if (lane == 0) begin
      v0[d] = valid; i0[d] = imm; e0[d] = e;
    end else begin
      v1[d] = valid; i1[d] = imm; e1[d] = e;
    end
  endtask

  task automatic refill_granted();
    for (int d = 0; d < 2; d++)
      if (g_prev[d] >= 0) new_req(d, g_prev[d], 1'b1);
  endtask

  logic [31:0] held;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      v0[d] = 0; v1[d] = 0; e0[d] = 0; e1[d] = 0; i0[d] = 0; i1[d] = 0; ordy[d] = 1;
      m_ov[d] = 0; m_od[d] = 0; m_ol[d] = 0; m_last[d] = 1; m_loss[d] = 0; g_prev[d] = -1;
    end
    cycle();
    cycle();
    rst = 1'b0;

    // Extension on lane 0 of the round-robin instance
    v0[0] = 1; i0[0] = 16'h8001; e0[0] = 1;
    cycle();
    chk("t2_sext", od[0], 32'hFFFF_8001);
    chk("t2_lane", 32'(ol[0]), 32'd0);
    e0[0] = 0;
    cycle();
    chk("t2_zext", od[0], 32'h0000_8001);
    i0[0] = 16'h7FFF; e0[0] = 1;
    cycle();
    chk("t2_sext_pos", od[0], 32'h0000_7FFF);
    v0[0] = 0;
    cycle();

    // Backpressure: lane 1 wins the tie after lane 0 won last
    new_req(0, 0, 1'b1);
    new_req(0, 1, 1'b1);
    ordy[0] = 0;
    cycle();
    chk("t4_first_lane", 32'(ol[0]), 32'd1);
    new_req(0, 1, 1'b1);
    held = od[0];
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t4_hold_data", od[0], held);
      chk("t4_no_ready", 32'(r0[0] | r1[0]), 32'd0);
    end
    ordy[0] = 1;
    cycle();
    chk("t4_drain_grant_valid", 32'(ov[0]), 32'd1);
    chk("t4_drain_grant_lane", 32'(ol[0]), 32'd0);

    // Single requester on lane 1
    v0[0] = 0;
    new_req(0, 1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t6_valid", 32'(ov[0]), 32'd1);
      chk("t6_lane", 32'(ol[0]), 32'd1);
      new_req(0, 1, 1'b1);
    end
    v1[0] = 0;
    cycle();

    // Reset with a result pending and requests active
    for (int d = 0; d < 2; d++) begin
      new_req(d, 0, 1'b1);
      ordy[d] = 0;
    end
    cycle();
    for (int d = 0; d < 2; d++) begin
      new_req(d, 0, 1'b1);
      new_req(d, 1, 1'b1);
    end
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle();
      for (int d = 0; d < 2; d++) begin
        chk("t1_valid_in_reset", 32'(ov[d]), 32'd0);
        chk("t1_ready_in_reset", 32'(r0[d] | r1[d]), 32'd0);
      end
    end
    rst = 1'b0;
    ordy[0] = 1;
    ordy[1] = 1;

    // Round-robin alternation and starvation guard, both lanes always valid
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (k < 6) begin
        chk("t3_valid", 32'(ov[0]), 32'd1);
        chk("t3_lane", 32'(ol[0]), 32'(k % 2));
      end
      chk("t5_lane", 32'(ol[1]), 32'((k % 4) == 3));
      refill_granted();
    end

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(99) == 0);
      for (int d = 0; d < 2; d++) begin
        ordy[d] = ($urandom_range(3) != 0);
        if (!v0[d] || g_prev[d] == 0) new_req(d, 0, $urandom_range(3) != 0);
        if (!v1[d] || g_prev[d] == 1) new_req(d, 1, $urandom_range(3) != 0);
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
